// File: rtl/fpga_cfg_pkg.sv
// Shared constants and FSM state encoding for the FPGA configuration loader.
package fpga_cfg_pkg;

  localparam int CFG_WIDTH  = 224;
  localparam int NUM_CHUNKS = 43;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    ARM,
    DONE,
    ERR
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module cfg_delay_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fpga_config_loader.sv
// Streams a bitstream into the fabric chunk by chunk, then settles,
// arms the fabric flip-flops and reports ready.
module fpga_config_loader #(
  parameter int CFG_WIDTH     = fpga_cfg_pkg::CFG_WIDTH,
  parameter int NUM_CHUNKS    = fpga_cfg_pkg::NUM_CHUNKS,
  parameter int SETTLE_CYCLES = 10,
  parameter int ARM_CYCLES    = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bs_valid,
  input  logic [CFG_WIDTH-1:0]  bs_data,
  input  logic                  bs_last,
  output logic                  bs_ready,
  output logic [CFG_WIDTH-1:0]  configs_in,
  output logic [NUM_CHUNKS-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);

  import fpga_cfg_pkg::*;

  localparam int DLY_W =
    $clog2(max2(SETTLE_CYCLES, ARM_CYCLES) + 1);
  localparam int CNT_W = $clog2(NUM_CHUNKS + 1);

  localparam logic [DLY_W-1:0] SET_LD =
    DLY_W'(SETTLE_CYCLES - 1);
  localparam logic [DLY_W-1:0] ARM_LD =
    DLY_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_K =
    CNT_W'(NUM_CHUNKS - 1);
  localparam logic [NUM_CHUNKS-1:0] ONE =
    NUM_CHUNKS'(1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]      chunk_q;
  logic [CFG_WIDTH-1:0]  cfg_q;
  logic [NUM_CHUNKS-1:0] en_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  ff_en_q;
  logic                  rdy_q;
  logic                  err_q;

  logic             accept;
  logic             last_chunk;
  logic             tmr_load;
  logic [DLY_W-1:0] tmr_val;
  logic             tmr_done;

  assign accept     = bs_valid && (state_q == LOAD);
  assign last_chunk = (chunk_q == LAST_K);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (bs_last != last_chunk) state_d = ERR;
          else if (bs_last)          state_d = SETTLE;
        end
      end
      SETTLE: if (tmr_done) state_d = ARM;
      ARM:    if (tmr_done) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Reload the delay on every entry into a timed state.
  assign tmr_load = (state_d != state_q) &&
                    ((state_d == SETTLE) || (state_d == ARM));
  assign tmr_val  = (state_d == SETTLE) ? SET_LD : ARM_LD;

  cfg_delay_timer #(
    .W (DLY_W)
  ) u_timer (
    .clock  (clock),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  // Status outputs are registered from the next state so they never glitch.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chunk_q <= '0;
      cfg_q   <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ff_en_q <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= '0;
      if (accept) begin
        cfg_q   <= bs_data;
        en_q    <= ONE << chunk_q;
        chunk_q <= chunk_q + 1'b1;
      end else if (state_d == LOAD && state_q != LOAD) begin
        chunk_q <= '0;
      end
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d == LOAD) || (state_d == SETTLE) ||
                 (state_d == ARM);
      ff_en_q <= (state_d == ARM) || (state_d == DONE);
      rdy_q   <= (state_d == DONE);
      err_q   <= (state_d == ERR);
    end
  end

  assign bs_ready   = ready_q;
  assign configs_in = cfg_q;
  assign configs_en = en_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
